// File: rtl/qmac_booth4.sv
// Sequential radix-4 Booth multiply-accumulate: two multiplier bits per cycle,
// early exit once the remaining multiplier bits are pure sign fill.
module qmac_booth4 #(
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [N-1:0]     a_din,
  input  logic [N-1:0]     b_din,
  input  logic             signed_mode,
  input  logic             acc_en,
  output logic [ACC_W-1:0] dout,
  output logic             dout_vld,
  output logic             dout_ovf
);

  localparam int PW    = 2*N + 2;
  localparam int QW    = N + 3;
  localparam int STEPS = N/2 + 1;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int SW    = ACC_W + 1;

  localparam logic [CW-1:0]    STEPS_C = CW'(STEPS);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     m_q, m_d;
  logic [QW-1:0]     q_q, q_d;
  logic [PW-1:0]     p_q, p_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              smode_q, smode_d;
  logic              accen_q, accen_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  dout_q, dout_d;
  logic              dvld_q, dvld_d;
  logic              dovf_q, dovf_d;

  logic              stop_s;
  logic [PW-1:0]     m2_s;
  logic [PW-1:0]     addend_s;
  logic [SW-1:0]     prod_ext_s;
  logic [SW-1:0]     acc_ext_s;
  logic [SW-1:0]     sum_s;
  logic              ovf_s;

  assign in_rdy   = (state_q == S_IDLE);
  assign dout     = dout_q;
  assign dout_vld = dvld_q;
  assign dout_ovf = dovf_q;

  assign stop_s = (q_q == {QW{1'b0}}) || (q_q == {QW{1'b1}});
  assign m2_s   = {m_q[PW-2:0], 1'b0};

  // Booth digit selection from the low multiplier triplet
  always_comb begin
    addend_s = {PW{1'b0}};
    case (q_q[2:0])
      3'b001, 3'b010: addend_s = m_q;
      3'b011:         addend_s = m2_s;
      3'b100:         addend_s = -m2_s;
      3'b101, 3'b110: addend_s = -m_q;
      default:        addend_s = {PW{1'b0}};
    endcase
  end

  // Product and sum are one bit wider than the accumulator so overflow is visible
  always_comb begin
    if (smode_q) begin
      prod_ext_s = {{(SW-2*N){p_q[2*N-1]}}, p_q[2*N-1:0]};
    end else begin
      prod_ext_s = {{(SW-2*N){1'b0}}, p_q[2*N-1:0]};
    end
    if (accen_q) begin
      acc_ext_s = {acc_q[ACC_W-1], acc_q};
    end else begin
      acc_ext_s = {SW{1'b0}};
    end
    sum_s = acc_ext_s + prod_ext_s;
    ovf_s = sum_s[SW-1] ^ sum_s[SW-2];
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    smode_d = smode_q;
    accen_d = accen_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    dovf_d  = dovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          smode_d = signed_mode;
          accen_d = acc_en;
          if (signed_mode) begin
            m_d = {{(PW-N){a_din[N-1]}}, a_din};
            q_d = {{2{b_din[N-1]}}, b_din, 1'b0};
          end else begin
            m_d = {{(PW-N){1'b0}}, a_din};
            q_d = {2'b00, b_din, 1'b0};
          end
          p_d     = {PW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (stop_s || (cnt_q == STEPS_C)) begin
          state_d = S_DONE;
        end else begin
          p_d   = p_q + addend_s;
          m_d   = {m_q[PW-3:0], 2'b00};
          q_d   = {{2{q_q[QW-1]}}, q_q[QW-1:2]};
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if ((SAT != 0) && ovf_s) begin
          acc_d = sum_s[SW-1] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_d = sum_s[ACC_W-1:0];
        end
        dout_d  = acc_d;
        dovf_d  = ovf_s;
        dvld_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= {PW{1'b0}};
      q_q     <= {QW{1'b0}};
      p_q     <= {PW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      smode_q <= 1'b0;
      accen_q <= 1'b0;
      acc_q   <= {ACC_W{1'b0}};
      dout_q  <= {ACC_W{1'b0}};
      dvld_q  <= 1'b0;
      dovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      smode_q <= smode_d;
      accen_q <= accen_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      dovf_q  <= dovf_d;
    end
  end

endmodule

// File: tb/tb_qmac_booth4.sv
// Directed table-driven bench for qmac_booth4: a 32-bit wrapping instance plus
// 16-bit saturating and wrapping instances for the overflow corners.
module tb_qmac_booth4;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_vld, sm, ae;
  logic [7:0]  a_din, b_din;
  logic        in_rdy, dvld, dovf;
  logic [31:0] dout;

  logic        v16, sm16, ae16;
  logic [7:0]  a16, b16;
  logic        rdy_s, vld_s, ovf_s, rdy_w, vld_w, ovf_w;
  logic [15:0] dout_s, dout_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qmac_booth4 #(.N(8), .ACC_W(32), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .a_din(a_din), .b_din(b_din), .signed_mode(sm), .acc_en(ae),
    .dout(dout), .dout_vld(dvld), .dout_ovf(dovf)
  );

  qmac_booth4 #(.N(8), .ACC_W(16), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_vld(v16), .in_rdy(rdy_s),
    .a_din(a16), .b_din(b16), .signed_mode(sm16), .acc_en(ae16),
    .dout(dout_s), .dout_vld(vld_s), .dout_ovf(ovf_s)
  );

  qmac_booth4 #(.N(8), .ACC_W(16), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_vld(v16), .in_rdy(rdy_w),
    .a_din(a16), .b_din(b16), .signed_mode(sm16), .acc_en(ae16),
    .dout(dout_w), .dout_vld(vld_w), .dout_ovf(ovf_w)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic        ae;
    logic [31:0] exp;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Counts edges after an accept until dout_vld shows; in_rdy must stay low meanwhile
  task automatic wait_vld(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (dvld) break;
      chk("rdy_busy", {63'd0, in_rdy}, 64'd0);
    end
    if (!dvld) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic e, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rdy_idle", {63'd0, in_rdy}, 64'd1);
    in_vld = 1'b1; a_din = a; b_din = b; sm = s; ae = e;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    wait_vld(lat);
  endtask

  task automatic run16(input logic e, input logic [15:0] exp_s, input logic ovf_s_exp,
                       input logic [15:0] exp_w, input logic ovf_w_exp);
    int n;
    @(negedge clk);
    v16 = 1'b1; a16 = 8'h80; b16 = 8'h80; sm16 = 1'b1; ae16 = e;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    n = 0;
    while (!vld_s && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sat_vld", {62'd0, vld_s, vld_w}, 64'd3);
    chk("sat_dout", {48'd0, dout_s}, {48'd0, exp_s});
    chk("sat_ovf", {63'd0, ovf_s}, {63'd0, ovf_s_exp});
    chk("wrap_dout", {48'd0, dout_w}, {48'd0, exp_w});
    chk("wrap_ovf", {63'd0, ovf_w}, {63'd0, ovf_w_exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] b2b_exp[4];

    tv[0] = '{a: 8'hFD, b: 8'h05, sm: 1'b1, ae: 1'b0, exp: 32'hFFFFFFF1, ovf: 1'b0, lat: 4};
    tv[1] = '{a: 8'h7F, b: 8'h00, sm: 1'b1, ae: 1'b0, exp: 32'h00000000, ovf: 1'b0, lat: 2};
    tv[2] = '{a: 8'hFF, b: 8'hFF, sm: 1'b0, ae: 1'b0, exp: 32'h0000FE01, ovf: 1'b0, lat: 7};
    tv[3] = '{a: 8'hFF, b: 8'hFF, sm: 1'b1, ae: 1'b0, exp: 32'h00000001, ovf: 1'b0, lat: 3};
    tv[4] = '{a: 8'h7F, b: 8'h81, sm: 1'b1, ae: 1'b1, exp: 32'hFFFFC100, ovf: 1'b0, lat: 6};
    tv[5] = '{a: 8'h80, b: 8'h80, sm: 1'b0, ae: 1'b0, exp: 32'h00004000, ovf: 1'b0, lat: 7};
    tv[6] = '{a: 8'h80, b: 8'h7F, sm: 1'b1, ae: 1'b1, exp: 32'h00000080, ovf: 1'b0, lat: 6};
    tv[7] = '{a: 8'h03, b: 8'h02, sm: 1'b0, ae: 1'b1, exp: 32'h00000086, ovf: 1'b0, lat: 4};
    tv[8] = '{a: 8'h05, b: 8'hFF, sm: 1'b1, ae: 1'b1, exp: 32'h00000081, ovf: 1'b0, lat: 3};
    b2b_exp = '{32'd16384, 32'd32768, 32'd49152, 32'd65536};

    rst_n = 1'b0;
    in_vld = 1'b0; a_din = 8'd0; b_din = 8'd0; sm = 1'b0; ae = 1'b0;
    v16 = 1'b0; a16 = 8'd0; b16 = 8'd0; sm16 = 1'b0; ae16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", {32'd0, dout}, 64'd0);
    chk("rst_vld", {63'd0, dvld}, 64'd0);
    chk("rst_ovf", {63'd0, dovf}, 64'd0);
    chk("rst_rdy", {63'd0, in_rdy}, 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].sm, tv[i].ae, lat);
      chk($sformatf("v%0d_dout", i), {32'd0, dout}, {32'd0, tv[i].exp});
      chk($sformatf("v%0d_ovf", i), {63'd0, dovf}, {63'd0, tv[i].ovf});
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].lat));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), {63'd0, dvld}, 64'd0);
      chk($sformatf("v%0d_hold", i), {32'd0, dout}, {32'd0, tv[i].exp});
    end

    // Back-to-back: in_vld held high, each accept lands on the previous dout_vld
    @(negedge clk);
    in_vld = 1'b1; a_din = 8'h80; b_din = 8'h80; sm = 1'b1; ae = 1'b0;
    @(posedge clk);
    #1;
    ae = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_vld(lat);
      chk($sformatf("b2b%0d_dout", k), {32'd0, dout}, {32'd0, b2b_exp[k]});
      chk($sformatf("b2b%0d_lat", k), 64'(lat), 64'd6);
      chk($sformatf("b2b%0d_rdy", k), {63'd0, in_rdy}, 64'd1);
      if (k == 3) begin
        in_vld = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end

    run16(1'b0, 16'h4000, 1'b0, 16'h4000, 1'b0);
    run16(1'b1, 16'h7FFF, 1'b1, 16'h8000, 1'b1);

    // Reset mid-CALC aborts the op and clears the accumulator
    @(negedge clk);
    in_vld = 1'b1; a_din = 8'hFF; b_din = 8'hFF; sm = 1'b0; ae = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", {32'd0, dout}, 64'd0);
    chk("mid_rst_vld", {63'd0, dvld}, 64'd0);
    chk("mid_rst_rdy", {63'd0, in_rdy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h07, 8'hFA, 1'b1, 1'b1, lat);
    chk("post_rst_dout", {32'd0, dout}, 64'hFFFFFFD6);
    chk("post_rst_lat", 64'(lat), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
